param_bit_counter: RTL
======================

Name: param_bit_counter

Overview:
- Parametrised successor to the team's 8-bit ones-counter.
- Counts set bits (mode=0) or clear bits (mode=1) in a WIDTH-bit operand, BPC bits per clock.
- Terminates early once no remaining bits can contribute.
- Standalone datapath+FSM, driven by a start/done handshake from a controller or testbench.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥1 and a multiple of BPC.
- BPC, 1, bits consumed per cycle (chunk size); 1 ≤ BPC ≤ WIDTH.
- RW, $clog2(WIDTH+1), result width (derived; not overridden by users).

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; level-sensitive handshake
- A  in  WIDTH  operand; sampled only in S_IDLE
- mode  in  1  0 = count ones, 1 = count zeros; sampled with A
- result  out  RW  count; valid while done=1
- done  out  1  high in S_DONE
- busy  out  1  high in S_COUNT

Behaviour:
- Reset (clk edge with reset=1):
  - state→S_IDLE; sreg=0; result=0; done=0; busy=0.
  - Reset overrides every other input, including mid-count.
- State S_IDLE (done=0, busy=0):
  - Each edge with start=0: sreg←(mode ? ~A : A); result←0.
  - Edge with start=1: →S_COUNT. sreg/result hold the value loaded on the prior start=0 edge.
  - start must be low ≥1 edge before rising for the load to take effect.
- State S_COUNT (busy=1):
  - If sreg==0: →S_DONE, no update.
  - Else: result←result+popcount(sreg[BPC-1:0]); sreg←sreg>>BPC (zero-fill); stay.
  - A, mode and start are ignored here.
- State S_DONE (done=1):
  - result holds.
  - start=1: stay.
  - start=0: →S_IDLE. The same edge performs the IDLE load, so done drops one edge after start falls.
- Latency:
  - k = index of highest contributing chunk + 1 (k=0 if the loaded sreg is zero).
  - done rises after the (k+1)th edge following the edge that sampled start=1.
  - Worst case WIDTH/BPC+1 edges.
- Arithmetic:
  - result never exceeds WIDTH, so RW bits suffice; no wrap-around.
  - popcount of a chunk is zero-extended to RW.
- Boundary cases:
  - Operand all non-contributing: done after exactly 1 COUNT edge, result=0.
  - Top chunk contributing: full WIDTH/BPC chunks processed.
  - start held high across DONE: no restart until start is deasserted.

Optional Feature:
- Macro: BIT_COUNTER_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - An edge in S_COUNT with abort=1 and reset=0 →S_IDLE; result←0; sreg←0; busy drops next cycle.
  - abort is ignored in S_IDLE and S_DONE.
  - Priority: reset > abort > count.
- Undefined:
  - No abort port.
  - S_COUNT exits only via sreg==0 or reset.

Test Plan:
1. WIDTH=8, BPC=1, mode=0, A=8'b10101010: start low 1 edge, then high → busy for 9 edges; done after 9th edge; result=4; holds until start low.
2. WIDTH=8, BPC=1, mode=0, A=8'b01010101 → result=4, done after 8 edges (early termination, k=7). Then A=8'hFF → result=8, done after 9 edges.
3. WIDTH=8, BPC=1, mode=1: A=8'hFF → result=0, done after 1 edge. A=8'h00 → result=8, done after 9 edges.
4. WIDTH=8, BPC=2, A=8'hFF → result=8, done after 5 edges. WIDTH=16, BPC=4, A=16'h8001 → result=2, done after 5 edges.
5. Reset mid-count: A=8'hFF, assert reset on 3rd COUNT edge → next cycle result=0, done=0, busy=0, state IDLE. Restart yields 8.
6. With BIT_COUNTER_ABORT_EN: A=8'hFF, abort on 2nd COUNT edge → busy=0, result=0. Start held high with abort=0 re-enters COUNT from the zeroed sreg and completes with result=0. Lowering start first (reload), then raising it → result=8.

Source files
------------

// File: rtl/param_bit_counter.sv
// Counts set or clear bits of an operand, BPC bits per clock, and stops early
// once no contributing bits remain. Define BIT_COUNTER_ABORT_EN to add i_abort.
module param_bit_counter #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1,
  parameter int RW    = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_mode,
`ifdef BIT_COUNTER_ABORT_EN
  input  logic             i_abort,
`endif
  output logic [RW-1:0]    o_result,
  output logic             o_done,
  output logic             o_busy
);

  // state   | meaning
  // S_IDLE  | load operand (inverted for zero count) while start is low
  // S_COUNT | accumulate the low chunk and shift until the shifter is empty
  // S_DONE  | hold result until start is released
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_nxt;
  logic [RW-1:0]    r_result;
  logic [RW-1:0]    w_result_nxt;
  logic [WIDTH-1:0] w_load;

  function automatic logic [RW-1:0] chunk_pop(input logic [BPC-1:0] c);
    logic [RW-1:0] n;
    n = '0;
    for (int i = 0; i < BPC; i++) begin
      n = n + RW'(c[i]);
    end
    return n;
  endfunction

  assign w_load = i_mode ? ~i_a : i_a;

  always_comb begin
    w_state_nxt  = r_state;
    w_sreg_nxt   = r_sreg;
    w_result_nxt = r_result;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_COUNT;
        end else begin
          w_sreg_nxt   = w_load;
          w_result_nxt = '0;
        end
      end
      S_COUNT: begin
`ifdef BIT_COUNTER_ABORT_EN
        if (i_abort) begin
          w_state_nxt  = S_IDLE;
          w_sreg_nxt   = '0;
          w_result_nxt = '0;
        end else
`endif
        if (r_sreg == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_result_nxt = r_result + chunk_pop(r_sreg[BPC-1:0]);
          w_sreg_nxt   = r_sreg >> BPC;
        end
      end
      S_DONE: begin
        // releasing start performs the idle load on the same edge
        if (!i_start) begin
          w_state_nxt  = S_IDLE;
          w_sreg_nxt   = w_load;
          w_result_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_sreg   <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sreg   <= w_sreg_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign o_result = r_result;
  assign o_done   = (r_state == S_DONE);
  assign o_busy   = (r_state == S_COUNT);

endmodule
